// File: rtl/id_ex_stage_buf_pkg.sv
// id_ex_stage_buf_pkg: shared widths, field offsets and stage-state encoding for the ID/EX buffer
//   XLEN_DEF/RAW_DEF/NUM_RF_DEF/CTRL_W_DEF  default core widths
//   PAYLOAD_W                               packed payload width at the default widths
//   ch_w/ch_off/payload_w                   layout helpers for any width set
//   state_t                                 EMPTY / ONE / TWO occupancy states
package id_ex_stage_buf_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int RAW_DEF    = 5;
    localparam int NUM_RF_DEF = 2;
    localparam int CTRL_W_DEF = 16;
    localparam int F_RD1 = 0;
    localparam int F_RD2 = 1;
    localparam int F_RS1 = 2;
    localparam int F_RS2 = 3;
    localparam int F_RD  = 4;
    function automatic int ch_w(int xlen, int raw);
        return 2*xlen + 3*raw;
    endfunction
    function automatic int ch_off(int f, int xlen, int raw);
        return f == F_RD1 ? 0 : f == F_RD2 ? xlen : f == F_RS1 ? 2*xlen :
               f == F_RS2 ? 2*xlen + raw : 2*xlen + 2*raw;
    endfunction
    function automatic int payload_w(int xlen, int raw, int num_rf, int ctrl_w);
        return num_rf*ch_w(xlen, raw) + 3*xlen + ctrl_w;
    endfunction
    localparam int PAYLOAD_W = payload_w(XLEN_DEF, RAW_DEF, NUM_RF_DEF, CTRL_W_DEF);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
endpackage

// File: rtl/id_ex_stage_buf_slot.sv
// stage_slot: one payload register with a valid bit
//   clk, reset (async, active-high), clr (sync, wins over load), load
//   din -> q, valid
module stage_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         valid
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= din;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/id_ex_stage_buf.sv
// id_ex_stage_buf: valid/ready decode->execute stage with optional one-entry skid slot
//   clk, reset (async, active-high), flush (sync kill)
//   in_valid/in_ready + rd1_d, rd2_d, rs1_d, rs2_d, rdst_d, pc_d, pc4_d, imm_d, ctrl_d
//   out_valid/out_ready + rd1_e, rd2_e, rs1_e, rs2_e, rdst_e, pc_e, pc4_e, imm_e, ctrl_e
module id_ex_stage_buf
    import id_ex_stage_buf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RAW    = RAW_DEF,
    parameter int NUM_RF = NUM_RF_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int SKID   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_RF*XLEN-1:0] rd1_d,
    input  logic [NUM_RF*XLEN-1:0] rd2_d,
    input  logic [NUM_RF*RAW-1:0]  rs1_d,
    input  logic [NUM_RF*RAW-1:0]  rs2_d,
    input  logic [NUM_RF*RAW-1:0]  rdst_d,
    input  logic [XLEN-1:0]        pc_d,
    input  logic [XLEN-1:0]        pc4_d,
    input  logic [XLEN-1:0]        imm_d,
    input  logic [CTRL_W-1:0]      ctrl_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_RF*XLEN-1:0] rd1_e,
    output logic [NUM_RF*XLEN-1:0] rd2_e,
    output logic [NUM_RF*RAW-1:0]  rs1_e,
    output logic [NUM_RF*RAW-1:0]  rs2_e,
    output logic [NUM_RF*RAW-1:0]  rdst_e,
    output logic [XLEN-1:0]        pc_e,
    output logic [XLEN-1:0]        pc4_e,
    output logic [XLEN-1:0]        imm_e,
    output logic [CTRL_W-1:0]      ctrl_e
);
    localparam int CW = ch_w(XLEN, RAW);
    localparam int PW = payload_w(XLEN, RAW, NUM_RF, CTRL_W);
    localparam int TB = NUM_RF*CW;
    logic [PW-1:0] pay_d, main_q, skid_q, main_din;
    logic main_v, acc, rel, main_load, main_clr;
    state_t state, state_nx;
    for (genvar k = 0; k < NUM_RF; k++) begin : g_ch
        assign pay_d[k*CW + ch_off(F_RD1, XLEN, RAW) +: XLEN] = rd1_d[k*XLEN +: XLEN];
        assign pay_d[k*CW + ch_off(F_RD2, XLEN, RAW) +: XLEN] = rd2_d[k*XLEN +: XLEN];
        assign pay_d[k*CW + ch_off(F_RS1, XLEN, RAW) +: RAW]  = rs1_d[k*RAW +: RAW];
        assign pay_d[k*CW + ch_off(F_RS2, XLEN, RAW) +: RAW]  = rs2_d[k*RAW +: RAW];
        assign pay_d[k*CW + ch_off(F_RD, XLEN, RAW) +: RAW]   = rdst_d[k*RAW +: RAW];
        assign rd1_e[k*XLEN +: XLEN] = main_q[k*CW + ch_off(F_RD1, XLEN, RAW) +: XLEN];
        assign rd2_e[k*XLEN +: XLEN] = main_q[k*CW + ch_off(F_RD2, XLEN, RAW) +: XLEN];
        assign rs1_e[k*RAW +: RAW]   = main_q[k*CW + ch_off(F_RS1, XLEN, RAW) +: RAW];
        assign rs2_e[k*RAW +: RAW]   = main_q[k*CW + ch_off(F_RS2, XLEN, RAW) +: RAW];
        assign rdst_e[k*RAW +: RAW]  = main_q[k*CW + ch_off(F_RD, XLEN, RAW) +: RAW];
    end
    assign pay_d[TB +: XLEN]          = pc_d;
    assign pay_d[TB + XLEN +: XLEN]   = pc4_d;
    assign pay_d[TB + 2*XLEN +: XLEN] = imm_d;
    assign pay_d[TB + 3*XLEN +: CTRL_W] = ctrl_d;
    assign pc_e   = main_q[TB +: XLEN];
    assign pc4_e  = main_q[TB + XLEN +: XLEN];
    assign imm_e  = main_q[TB + 2*XLEN +: XLEN];
    assign ctrl_e = main_q[TB + 3*XLEN +: CTRL_W];
    assign acc       = in_valid & in_ready;
    assign rel       = out_valid & out_ready;
    assign out_valid = main_v;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = flush ? EMPTY :
                   state == EMPTY ? (acc ? ONE : EMPTY) :
                   state == ONE   ? (acc && !rel ? TWO : rel && !acc ? EMPTY : ONE) :
                                    (rel ? ONE : TWO);
    end
    // Main refills from skid when it drains in TWO, otherwise straight from decode.
    always_comb begin
        main_load = (state == EMPTY && acc) || (state == ONE && acc && rel) || (state == TWO && rel);
        main_clr  = flush || (state == ONE && rel && !acc);
        main_din  = state == TWO ? skid_q : pay_d;
    end
    stage_slot #(.W(PW)) u_main (
        .clk(clk), .reset(reset), .clr(main_clr), .load(main_load),
        .din(main_din), .q(main_q), .valid(main_v)
    );
    if (SKID != 0) begin : g_skid
        logic skid_v, skid_load, skid_clr;
        assign skid_load = state == ONE && acc && !rel;
        assign skid_clr  = flush || (state == TWO && rel);
        // in_ready comes straight from a flop, so EX stalls never reach decode combinationally.
        assign in_ready  = ~skid_v;
        stage_slot #(.W(PW)) u_skid (
            .clk(clk), .reset(reset), .clr(skid_clr), .load(skid_load),
            .din(pay_d), .q(skid_q), .valid(skid_v)
        );
    end else begin : g_noskid
        assign skid_q   = '0;
        assign in_ready = out_ready | ~main_v;
    end
endmodule

// File: tb/tb_id_ex_stage_buf.sv
// tb_id_ex_stage_buf: scoreboard bench for id_ex_stage_buf (SKID=1 model-checked, SKID=0 directed)
module tb_id_ex_stage_buf;
    typedef struct packed {
        logic [63:0] rd1, rd2;
        logic [9:0]  rs1, rs2, rdst;
        logic [31:0] pc, pc4, imm;
        logic [15:0] ctrl;
    } pl_t;
    logic clk = 1'b0, reset, flush, in_valid, out_ready;
    logic [63:0] rd1_d, rd2_d;
    logic [9:0]  rs1_d, rs2_d, rdst_d;
    logic [31:0] pc_d, pc4_d, imm_d;
    logic [15:0] ctrl_d;
    logic in_ready, out_valid, in_ready0, out_valid0;
    logic [63:0] rd1_e, rd2_e, rd1_e0, rd2_e0;
    logic [9:0]  rs1_e, rs2_e, rdst_e, rs1_e0, rs2_e0, rdst_e0;
    logic [31:0] pc_e, pc4_e, imm_e, pc_e0, pc4_e0, imm_e0;
    logic [15:0] ctrl_e, ctrl_e0;
    pl_t sb[$];
    int n_pass = 0, n_fail = 0, n_tot = 0;
    always #5 clk = ~clk;
    id_ex_stage_buf #(.SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rdst_d(rdst_d),
        .pc_d(pc_d), .pc4_d(pc4_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rdst_e(rdst_e),
        .pc_e(pc_e), .pc4_e(pc4_e), .imm_e(imm_e), .ctrl_e(ctrl_e)
    );
    id_ex_stage_buf #(.SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rdst_d(rdst_d),
        .pc_d(pc_d), .pc4_d(pc4_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
        .out_valid(out_valid0), .out_ready(out_ready),
        .rd1_e(rd1_e0), .rd2_e(rd2_e0), .rs1_e(rs1_e0), .rs2_e(rs2_e0), .rdst_e(rdst_e0),
        .pc_e(pc_e0), .pc4_e(pc4_e0), .imm_e(imm_e0), .ctrl_e(ctrl_e0)
    );
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_pl(string tag, pl_t obs, pl_t exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic pl_t mk(logic [31:0] pc);
        pl_t p;
        p.rd1  = {pc ^ 32'hF0F0_0000, pc};
        p.rd2  = {~pc, pc + 32'd1};
        p.rs1  = {pc[6:2], pc[11:7]};
        p.rs2  = {pc[4:0], ~pc[4:0]};
        p.rdst = {pc[9:5], pc[6:2]};
        p.pc   = pc;
        p.pc4  = pc + 32'd4;
        p.imm  = ~pc;
        p.ctrl = pc[15:0] ^ 16'h8001;
        return p;
    endfunction
    task automatic drive(pl_t p);
        {rd1_d, rd2_d, rs1_d, rs2_d, rdst_d, pc_d, pc4_d, imm_d, ctrl_d} = p;
    endtask
    // One clock: compare DUT against the queue model at negedge, then update the model.
    task automatic tick();
        pl_t obs, inp;
        bit m_val, m_rdy;
        @(negedge clk);
        m_val = sb.size() > 0;
        m_rdy = sb.size() < 2;
        obs = {rd1_e, rd2_e, rs1_e, rs2_e, rdst_e, pc_e, pc4_e, imm_e, ctrl_e};
        inp = {rd1_d, rd2_d, rs1_d, rs2_d, rdst_d, pc_d, pc4_d, imm_d, ctrl_d};
        chk("out_valid", 64'(out_valid), 64'(m_val));
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
        chk_pl("payload", obs, m_val ? sb[0] : '0);
        if (flush) sb.delete();
        else begin
            if (m_val && out_ready) void'(sb.pop_front());
            if (in_valid && m_rdy) sb.push_back(inp);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        pl_t p;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive('0);
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pc_e", 64'(pc_e), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
        // streaming
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(mk(32'h100 + 32'(4*i)));
            tick();
            if (i > 0) chk("stream_pc", 64'(pc_e), 64'(32'h100 + 32'(4*i)));
        end
        in_valid = 1'b0;
        tick();
        // stall with skid
        in_valid = 1'b1; out_ready = 1'b0; drive(mk(32'h200));
        tick();
        drive(mk(32'h204));
        tick();
        for (int i = 0; i < 2; i++) begin
            chk("stall_pc_hold", 64'(pc_e), 64'h200);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        chk("stall_pc_hold", 64'(pc_e), 64'h200);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("skid_to_main", 64'(pc_e), 64'h204);
        tick();
        // flush in TWO, then in ONE with in_ready=1
        in_valid = 1'b1; out_ready = 1'b0; drive(mk(32'h280));
        tick();
        drive(mk(32'h284));
        tick();
        flush = 1'b1; drive(mk(32'h300));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", 64'(out_valid), 64'd0);
        chk("flush2_pc", 64'(pc_e), 64'd0);
        chk("flush2_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b1; drive(mk(32'h400));
        tick();
        flush = 1'b1; drive(mk(32'h304));
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("flush1_pc", 64'(pc_e), 64'd0);
        // channel isolation
        p = mk(32'h500);
        p.rd1 = 64'h5555_5555_AAAA_AAAA;
        p.rdst = {5'd17, 5'd5};
        in_valid = 1'b1; drive(p);
        tick();
        in_valid = 1'b0;
        chk("ch_rd1", rd1_e, 64'h5555_5555_AAAA_AAAA);
        chk("ch_rdst", 64'(rdst_e), 64'({5'd17, 5'd5}));
        tick();
        tick();
        // SKID=0 stall
        in_valid = 1'b1; out_ready = 1'b0; drive(mk(32'h200));
        tick();
        drive(mk(32'h204));
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("s0_in_ready_lo", 64'(in_ready0), 64'd0);
            chk("s0_pc_hold", 64'(pc_e0), 64'h200);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("s0_in_ready_hi", 64'(in_ready0), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("s0_pc_next", 64'(pc_e0), 64'h204);
        chk("s0_valid", 64'(out_valid0), 64'd1);
        tick();
        tick();
        // reset with both slots full
        in_valid = 1'b1; out_ready = 1'b0; drive(mk(32'h600));
        tick();
        drive(mk(32'h604));
        tick();
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_rd1", rd1_e, 64'd0);
        chk("arst_ctrl", 64'(ctrl_e), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("arst_in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
